// File: rtl/reorder_buffer.sv
// Reorder buffer: tags dispatched instrs, captures CDB results, retires in order.
// Ports: alloc_*, cdb_*, rdest_*/rd_bus snoop view, flush_*, commit_*.
module reorder_buffer #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_alloc_valid,
  input  logic [4:0]                  i_alloc_rd,
  input  logic                        i_alloc_is_br,
  output logic                        o_alloc_ready,
  output logic [3:0]                  o_alloc_tag,
  input  logic                        i_cdb_valid,
  input  logic [3:0]                  i_cdb_tag,
  input  logic [WIDTH-1:0]            i_cdb_data,
  input  logic                        i_cdb_mispredict,
  output logic [SIZE-1:0]             o_rdest_rdy,
  output logic [SIZE-1:0][3:0]        o_rdest_tag,
  output logic [SIZE-1:0][WIDTH-1:0]  o_rdest_data,
  output logic [SIZE-1:0][4:0]        o_rd_bus,
  output logic                        o_flush_valid,
  output logic [3:0]                  o_flush_front_tag,
  output logic [3:0]                  o_flush_tag,
  output logic                        o_commit_valid,
  output logic [3:0]                  o_commit_tag
);

  localparam int PW = $clog2(SIZE);
  localparam int CW = PW + 1;

  logic [SIZE-1:0]            r_valid;
  logic [SIZE-1:0]            r_rdy;
  logic [SIZE-1:0]            r_br;
  logic [SIZE-1:0]            r_mis;
  logic [SIZE-1:0][WIDTH-1:0] r_data;
  logic [SIZE-1:0][4:0]       r_rd;
  logic [PW-1:0]              r_front;
  logic [PW-1:0]              r_rear;
  logic [CW-1:0]              r_count;
  logic                       r_flush_valid;
  logic [3:0]                 r_flush_front;
  logic [3:0]                 r_flush_tag;
  logic                       r_commit_valid;
  logic [3:0]                 r_commit_tag;

  logic          w_alloc;
  logic          w_commit;
  logic          w_squash;
  logic          w_cdb;
  logic [PW-1:0] w_cdb_idx;
  logic [PW-1:0] w_front_nx;
  logic [PW-1:0] w_rear_nx;

  assign o_alloc_ready = (r_count < CW'(SIZE)) && !r_flush_valid;
  assign o_alloc_tag   = 4'(r_rear);

  assign w_alloc    = i_alloc_valid && o_alloc_ready;
  assign w_front_nx = r_front + 1'b1;
  assign w_rear_nx  = r_rear + 1'b1;
  assign w_commit   = (r_count != '0) && r_rdy[r_front];
  // a retiring mispredicted branch squashes everything younger
  assign w_squash   = w_commit && r_br[r_front] && r_mis[r_front];

  assign w_cdb_idx = i_cdb_tag[PW-1:0];
  // out-of-range tags and results for free/finished entries are dropped
  assign w_cdb = i_cdb_valid && !r_flush_valid
              && ({1'b0, i_cdb_tag} < 5'(SIZE))
              && r_valid[w_cdb_idx] && !r_rdy[w_cdb_idx];

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      o_rdest_tag[i] = 4'(i);
    end
  end

  assign o_rdest_rdy       = r_rdy;
  assign o_rdest_data      = r_data;
  assign o_rd_bus          = r_rd;
  assign o_flush_valid     = r_flush_valid;
  assign o_flush_front_tag = r_flush_front;
  assign o_flush_tag       = r_flush_tag;
  assign o_commit_valid    = r_commit_valid;
  assign o_commit_tag      = r_commit_tag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid        <= '0;
      r_rdy          <= '0;
      r_br           <= '0;
      r_mis          <= '0;
      r_data         <= '0;
      r_rd           <= '0;
      r_front        <= '0;
      r_rear         <= '0;
      r_count        <= '0;
      r_flush_valid  <= 1'b0;
      r_flush_front  <= '0;
      r_flush_tag    <= '0;
      r_commit_valid <= 1'b0;
      r_commit_tag   <= '0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_commit) r_commit_tag <= 4'(r_front);
      r_flush_valid <= w_squash;
      if (w_squash) begin
        r_flush_front <= 4'(w_front_nx);
        r_flush_tag   <= 4'(r_rear);
        // same-cycle alloc and CDB are discarded
        r_valid <= '0;
        r_rdy   <= '0;
        r_br    <= '0;
        r_mis   <= '0;
        r_rd    <= '0;
        r_front <= w_front_nx;
        r_rear  <= w_front_nx;
        r_count <= '0;
      end else begin
        if (w_alloc) begin
          r_valid[r_rear] <= 1'b1;
          r_rdy[r_rear]   <= 1'b0;
          r_br[r_rear]    <= i_alloc_is_br;
          r_mis[r_rear]   <= 1'b0;
          r_rd[r_rear]    <= i_alloc_rd;
          r_rear          <= w_rear_nx;
        end
        if (w_cdb) begin
          r_data[w_cdb_idx] <= i_cdb_data;
          r_rdy[w_cdb_idx]  <= 1'b1;
          r_mis[w_cdb_idx]  <= i_cdb_mispredict;
        end
        // alloc targets rear, commit targets front: never the same
        // entry because alloc is blocked when full
        if (w_commit) begin
          r_valid[r_front] <= 1'b0;
          r_rdy[r_front]   <= 1'b0;
          r_br[r_front]    <= 1'b0;
          r_mis[r_front]   <= 1'b0;
          r_rd[r_front]    <= '0;
          r_front          <= w_front_nx;
        end
        r_count <= r_count + CW'(w_alloc) - CW'(w_commit);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Inputs driven and outputs sampled on the falling edge.
module tb_reorder_buffer;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic [4:0]      alloc_rd;
  logic            alloc_is_br;
  logic            alloc_ready;
  logic [3:0]      alloc_tag;
  logic            cdb_valid;
  logic [3:0]      cdb_tag;
  logic [31:0]     cdb_data;
  logic            cdb_mis;
  logic [7:0]      rdest_rdy;
  logic [7:0][3:0] rdest_tag;
  logic [7:0][31:0] rdest_data;
  logic [7:0][4:0] rd_bus;
  logic            flush_valid;
  logic [3:0]      flush_front;
  logic [3:0]      flush_tag;
  logic            commit_valid;
  logic [3:0]      commit_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.WIDTH(32), .SIZE(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_alloc_valid(alloc_valid),
    .i_alloc_rd(alloc_rd),
    .i_alloc_is_br(alloc_is_br),
    .o_alloc_ready(alloc_ready),
    .o_alloc_tag(alloc_tag),
    .i_cdb_valid(cdb_valid),
    .i_cdb_tag(cdb_tag),
    .i_cdb_data(cdb_data),
    .i_cdb_mispredict(cdb_mis),
    .o_rdest_rdy(rdest_rdy),
    .o_rdest_tag(rdest_tag),
    .o_rdest_data(rdest_data),
    .o_rd_bus(rd_bus),
    .o_flush_valid(flush_valid),
    .o_flush_front_tag(flush_front),
    .o_flush_tag(flush_tag),
    .o_commit_valid(commit_valid),
    .o_commit_tag(commit_tag)
  );

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_is_br = 1'b0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;
    cdb_mis     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %0h exp 1", alloc_ready); end
    n_cmp++; if (alloc_tag !== 4'd0) begin n_bad++; $display("FAIL rst_tag got %0h exp 0", alloc_tag); end
    n_cmp++; if (flush_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush got %0h exp 0", flush_valid); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL rst_commit got %0h exp 0", commit_valid); end
    n_cmp++; if (rdest_rdy !== 8'h00) begin n_bad++; $display("FAIL rst_rdy got %0h exp 0", rdest_rdy); end
    n_cmp++; if (rd_bus !== 40'h0) begin n_bad++; $display("FAIL rst_rdbus got %0h exp 0", rd_bus); end
    n_cmp++; if (rdest_data !== 256'h0) begin n_bad++; $display("FAIL rst_data got %0h exp 0", rdest_data); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rdest_tag[i] !== 4'(i)) begin n_bad++; $display("FAIL rdest_tag%0d got %0h exp %0h", i, rdest_tag[i], i); end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (alloc_tag !== 4'(i)) begin n_bad++; $display("FAIL fill_tag got %0h exp %0h", alloc_tag, i); end
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready%0d got %0h exp 1", i, alloc_ready); end
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 1);
      @(negedge clk);
    end
    idle();
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %0h exp 0", alloc_ready); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_bus[i] !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_rdbus%0d got %0h exp %0h", i, rd_bus[i], i + 1); end
    end
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL fill_commit got %0h exp 0", commit_valid); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready2 got %0h exp 0", alloc_ready); end
  endtask

  task automatic test_head_commit();
    cdb_valid = 1'b1;
    cdb_tag   = 4'd0;
    cdb_data  = 32'hAA;
    @(negedge clk);
    idle();
    n_cmp++; if (rdest_rdy[0] !== 1'b1) begin n_bad++; $display("FAIL head_rdy got %0h exp 1", rdest_rdy[0]); end
    n_cmp++; if (rdest_data[0] !== 32'hAA) begin n_bad++; $display("FAIL head_data got %0h exp aa", rdest_data[0]); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL head_early got %0h exp 0", commit_valid); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL head_ready0 got %0h exp 0", alloc_ready); end
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b1) begin n_bad++; $display("FAIL head_commit got %0h exp 1", commit_valid); end
    n_cmp++; if (commit_tag !== 4'd0) begin n_bad++; $display("FAIL head_ctag got %0h exp 0", commit_tag); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL head_ready1 got %0h exp 1", alloc_ready); end
    n_cmp++; if (rd_bus[0] !== 5'd0) begin n_bad++; $display("FAIL head_rdbus got %0h exp 0", rd_bus[0]); end
    n_cmp++; if (rdest_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL head_clr got %0h exp 0", rdest_rdy[0]); end
    n_cmp++; if (alloc_tag !== 4'd0) begin n_bad++; $display("FAIL head_atag got %0h exp 0", alloc_tag); end
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL head_pulse got %0h exp 0", commit_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 10);
      @(negedge clk);
    end
    idle();
    for (int i = 2; i >= 0; i--) begin
      cdb_valid = 1'b1;
      cdb_tag   = 4'(i);
      cdb_data  = 32'h100 + 32'(i);
      @(negedge clk);
      n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_early%0d got %0h exp 0", i, commit_valid); end
    end
    idle();
    n_cmp++; if (rdest_rdy[2:0] !== 3'b111) begin n_bad++; $display("FAIL ooo_rdy got %0h exp 7", rdest_rdy[2:0]); end
    n_cmp++; if (rdest_data[2] !== 32'h102) begin n_bad++; $display("FAIL ooo_data2 got %0h exp 102", rdest_data[2]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (commit_valid !== 1'b1) begin n_bad++; $display("FAIL ooo_cv%0d got %0h exp 1", i, commit_valid); end
      n_cmp++; if (commit_tag !== 4'(i)) begin n_bad++; $display("FAIL ooo_ct got %0h exp %0h", commit_tag, i); end
    end
    @(negedge clk);
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_end got %0h exp 0", commit_valid); end
    n_cmp++; if (alloc_tag !== 4'd3) begin n_bad++; $display("FAIL ooo_atag got %0h exp 3", alloc_tag); end
    n_cmp++; if (rd_bus !== 40'h0) begin n_bad++; $display("FAIL ooo_rdbus got %0h exp 0", rd_bus); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_is_br = (i == 0);
      alloc_rd    = 5'(i + 1);
      @(negedge clk);
    end
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h22;
    @(negedge clk);
    n_cmp++; if (rdest_rdy[2] !== 1'b1) begin n_bad++; $display("FAIL mp_rdy2 got %0h exp 1", rdest_rdy[2]); end
    cdb_tag = 4'd5; cdb_data = 32'h55;
    @(negedge clk);
    n_cmp++; if (rdest_rdy[5] !== 1'b0) begin n_bad++; $display("FAIL mp_drop got %0h exp 0", rdest_rdy[5]); end
    cdb_tag = 4'd0; cdb_data = 32'h0; cdb_mis = 1'b1;
    @(negedge clk);
    idle();
    n_cmp++; if (flush_valid !== 1'b0) begin n_bad++; $display("FAIL mp_early got %0h exp 0", flush_valid); end
    n_cmp++; if (alloc_tag !== 4'd4) begin n_bad++; $display("FAIL mp_atag4 got %0h exp 4", alloc_tag); end
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    @(negedge clk);
    alloc_rd  = 5'd10;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h77;
    n_cmp++; if (flush_valid !== 1'b1) begin n_bad++; $display("FAIL mp_flush got %0h exp 1", flush_valid); end
    n_cmp++; if (flush_front !== 4'd1) begin n_bad++; $display("FAIL mp_front got %0h exp 1", flush_front); end
    n_cmp++; if (flush_tag !== 4'd4) begin n_bad++; $display("FAIL mp_ftag got %0h exp 4", flush_tag); end
    n_cmp++; if (commit_valid !== 1'b1) begin n_bad++; $display("FAIL mp_cv got %0h exp 1", commit_valid); end
    n_cmp++; if (commit_tag !== 4'd0) begin n_bad++; $display("FAIL mp_ct got %0h exp 0", commit_tag); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL mp_ready got %0h exp 0", alloc_ready); end
    n_cmp++; if (rdest_rdy !== 8'h00) begin n_bad++; $display("FAIL mp_rdy got %0h exp 0", rdest_rdy); end
    n_cmp++; if (rd_bus !== 40'h0) begin n_bad++; $display("FAIL mp_rdbus got %0h exp 0", rd_bus); end
    n_cmp++; if (alloc_tag !== 4'd1) begin n_bad++; $display("FAIL mp_atag got %0h exp 1", alloc_tag); end
    @(negedge clk);
    idle();
    n_cmp++; if (flush_valid !== 1'b0) begin n_bad++; $display("FAIL mp_one got %0h exp 0", flush_valid); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL mp_cv2 got %0h exp 0", commit_valid); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL mp_resume got %0h exp 1", alloc_ready); end
    n_cmp++; if (alloc_tag !== 4'd1) begin n_bad++; $display("FAIL mp_atag2 got %0h exp 1", alloc_tag); end
    n_cmp++; if (rd_bus !== 40'h0) begin n_bad++; $display("FAIL mp_rdbus2 got %0h exp 0", rd_bus); end
    n_cmp++; if (rdest_rdy !== 8'h00) begin n_bad++; $display("FAIL mp_rdy3 got %0h exp 0", rdest_rdy); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 1);
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      cdb_valid = 1'b1;
      cdb_tag   = 4'(i);
      cdb_data  = 32'(i);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);
    n_cmp++; if (alloc_tag !== 4'd6) begin n_bad++; $display("FAIL wr_start got %0h exp 6", alloc_tag); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL wr_idle got %0h exp 0", commit_valid); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (alloc_tag !== 4'((i + 6) % 8)) begin n_bad++; $display("FAIL wr_tag got %0h exp %0h", alloc_tag, (i + 6) % 8); end
      alloc_valid = 1'b1;
      alloc_is_br = (i == 0);
      alloc_rd    = 5'(20 + i);
      @(negedge clk);
    end
    idle();
    n_cmp++; if (rd_bus[1] !== 5'd23) begin n_bad++; $display("FAIL wr_rdbus1 got %0h exp 17", rd_bus[1]); end
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_mis = 1'b1; cdb_data = 32'h6;
    @(negedge clk);
    idle();
    @(negedge clk);
    n_cmp++; if (flush_valid !== 1'b1) begin n_bad++; $display("FAIL wr_flush got %0h exp 1", flush_valid); end
    n_cmp++; if (flush_front !== 4'd7) begin n_bad++; $display("FAIL wr_front got %0h exp 7", flush_front); end
    n_cmp++; if (flush_tag !== 4'd2) begin n_bad++; $display("FAIL wr_ftag got %0h exp 2", flush_tag); end
    n_cmp++; if (commit_tag !== 4'd6) begin n_bad++; $display("FAIL wr_ct got %0h exp 6", commit_tag); end
    @(negedge clk);
    n_cmp++; if (alloc_tag !== 4'd7) begin n_bad++; $display("FAIL wr_atag got %0h exp 7", alloc_tag); end
    n_cmp++; if (rd_bus !== 40'h0) begin n_bad++; $display("FAIL wr_rdbus got %0h exp 0", rd_bus); end
  endtask

  task automatic test_rst_in_flush();
    do_reset();
    alloc_valid = 1'b1; alloc_is_br = 1'b1; alloc_rd = 5'd3;
    @(negedge clk);
    alloc_is_br = 1'b0; alloc_rd = 5'd4;
    @(negedge clk);
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_mis = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    n_cmp++; if (flush_valid !== 1'b1) begin n_bad++; $display("FAIL rf_flush got %0h exp 1", flush_valid); end
    n_cmp++; if (flush_tag !== 4'd2) begin n_bad++; $display("FAIL rf_ftag got %0h exp 2", flush_tag); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (flush_valid !== 1'b0) begin n_bad++; $display("FAIL rf_clr got %0h exp 0", flush_valid); end
    n_cmp++; if (flush_front !== 4'd0) begin n_bad++; $display("FAIL rf_front got %0h exp 0", flush_front); end
    n_cmp++; if (alloc_tag !== 4'd0) begin n_bad++; $display("FAIL rf_atag got %0h exp 0", alloc_tag); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rf_ready got %0h exp 1", alloc_ready); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL rf_cv got %0h exp 0", commit_valid); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_head_commit();
    test_out_of_order();
    test_mispredict();
    test_wrap();
    test_rst_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
